audio_lpf_decim: RTL

//  Real-valued decimating low-pass FIR on the demodulator output stream (mono audio path).

---
 rtl/audio_lpf_decim_pkg.sv | 30 +++
 rtl/audio_lpf_decim_if.sv | 25 ++
 rtl/audio_lpf_decim.sv | 94 +++++++++
 3 files changed

// File: rtl/audio_lpf_decim_pkg.sv
// Shared definitions for the mono audio decimating low-pass FIR.
//   QUANT_VAL        : Q10 scale factor (1.0 == 1024)
//   LPF_TAPS         : length of the coefficient table
//   state_t          : filter sequencing states
//   AUDIO_LPF_COEFFS : signed Q10 low-pass taps, symmetric
//   DEQUANTIZE       : Q20 -> Q10 rescale, truncating toward zero
package audio_lpf_decim_pkg;

   localparam int QUANT_VAL = 1024;
   localparam int LPF_TAPS  = 32;

   typedef enum logic [1:0] {
      LOAD,
      MAC,
      WRITE
   } state_t;

   localparam logic signed [31:0] AUDIO_LPF_COEFFS [LPF_TAPS] = '{
      32'sd1,  32'sd2,  32'sd3,  32'sd4,  32'sd6,  32'sd8,  32'sd10, 32'sd13,
      32'sd16, 32'sd20, 32'sd24, 32'sd28, 32'sd32, 32'sd36, 32'sd39, 32'sd41,
      32'sd41, 32'sd39, 32'sd36, 32'sd32, 32'sd28, 32'sd24, 32'sd20, 32'sd16,
      32'sd13, 32'sd10, 32'sd8,  32'sd6,  32'sd4,  32'sd3,  32'sd2,  32'sd1
   };

   // Signed division, not >>>: small negative products must round to 0, not -1.
   function automatic logic signed [31:0] DEQUANTIZE(input logic signed [31:0] v);
      return v / QUANT_VAL;
   endfunction

endpackage

// File: rtl/audio_lpf_decim_if.sv
// FIFO-side signals of the audio low-pass decimator.
//   in_empty / in_rd_en / din    : upstream (demod) FIFO read side
//   out_full / out_wr_en / dout  : downstream audio FIFO write side
// slave  : the filter
// master : whatever drives the FIFOs (the bench here)
interface audio_lpf_decim_if #(
   parameter int DATA_WIDTH = 32
);
   logic                         in_empty;
   logic                         in_rd_en;
   logic signed [DATA_WIDTH-1:0] din;
   logic                         out_full;
   logic                         out_wr_en;
   logic signed [DATA_WIDTH-1:0] dout;

   modport slave (
      input  in_empty, din, out_full,
      output in_rd_en, out_wr_en, dout
   );

   modport master (
      output in_empty, din, out_full,
      input  in_rd_en, out_wr_en, dout
   );
endinterface

// File: rtl/audio_lpf_decim.sv
// Decimating low-pass FIR on the demodulated mono audio stream.
// Pops DECIM Q10 samples into a TAPS-deep history, then runs a serial MAC
// (one tap per cycle, single multiplier) and pushes one filtered Q10 sample.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : FIFO handshake (audio_lpf_decim_if.slave)
//           in_rd_en  = LOAD  && !in_empty (din consumed same cycle)
//           out_wr_en = WRITE && !out_full (dout held until pushed)
module audio_lpf_decim
   import audio_lpf_decim_pkg::*;
#(
   parameter int TAPS       = 32,
   parameter int DECIM      = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   audio_lpf_decim_if.slave   bus
);

   localparam int TAP_W = (TAPS  > 1) ? $clog2(TAPS)  : 1;
   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   state_t                       state_q;
   logic signed [DATA_WIDTH-1:0] hist_q [TAPS];
   logic        [CNT_W-1:0]      load_cnt_q;
   logic        [TAP_W-1:0]      tap_idx_q;
   logic signed [31:0]           acc_q;
   logic signed [DATA_WIDTH-1:0] dout_q;

   logic                           pop;
   logic                           push;
   logic signed [DATA_WIDTH-1:0]   coef;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [31:0]             term;

   assign pop  = (state_q == LOAD)  && !bus.in_empty;
   assign push = (state_q == WRITE) && !bus.out_full;

   assign bus.in_rd_en  = pop;
   assign bus.out_wr_en = push;
   assign bus.dout      = dout_q;

   // One shared multiplier, indexed by the current tap.
   always_comb begin
      coef = AUDIO_LPF_COEFFS[tap_idx_q];
      prod = coef * hist_q[tap_idx_q];
      term = DEQUANTIZE(prod[31:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LOAD;
         for (int unsigned k = 0; k < TAPS; k++) hist_q[k] <= '0;
         load_cnt_q <= '0;
         tap_idx_q  <= '0;
         acc_q      <= '0;
         dout_q     <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (pop) begin
                  for (int unsigned k = 1; k < TAPS; k++) hist_q[k] <= hist_q[k-1];
                  hist_q[0] <= bus.din;
                  if (load_cnt_q == CNT_W'(DECIM - 1)) begin
                     load_cnt_q <= '0;
                     acc_q      <= '0;
                     tap_idx_q  <= '0;
                     state_q    <= MAC;
                  end else begin
                     load_cnt_q <= load_cnt_q + 1'b1;
                  end
               end
            end
            MAC: begin
               // Last tap folds straight into dout; acc wraps, never saturates.
               if (tap_idx_q == TAP_W'(TAPS - 1)) begin
                  dout_q  <= acc_q + term;
                  state_q <= WRITE;
               end else begin
                  acc_q     <= acc_q + term;
                  tap_idx_q <= tap_idx_q + 1'b1;
               end
            end
            WRITE: begin
               if (push) state_q <= LOAD;
            end
            default: state_q <= LOAD;
         endcase
      end
   end

endmodule
